// File: rtl/alu_arb_pkg.sv
// Shared opcode encodings and default operand width for the arbitrated ALU.
package alu_arb_pkg;

  parameter int unsigned DEFAULT_WIDTH = 4;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: WIDTH-bit operands, WIDTH+1-bit result (carry/borrow in the top bit).
module alu_core
  import alu_arb_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic [WIDTH:0]   result
);

  logic [WIDTH:0] a_ext;
  logic [WIDTH:0] b_ext;

  assign a_ext = {1'b0, a};
  assign b_ext = {1'b0, b};

  always_comb begin
    result = '0;
    case (op)
      OP_ADD:  result = a_ext + b_ext;
      OP_OR:   result = a_ext | b_ext;
      // Wraps modulo 2^(WIDTH+1), so a borrow shows up as a set top bit.
      OP_SUB:  result = a_ext - b_ext;
      OP_XOR:  result = a_ext ^ b_ext;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Two-requester round-robin front end for a shared ALU with a single-entry result register.
module alu_rr_arbiter
  import alu_arb_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [1:0]       req0_op,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [1:0]       req1_op,
  output logic             req1_ready,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH:0]   res_data,
  output logic             res_id,
  output logic [7:0]       grant_cnt0,
  output logic [7:0]       grant_cnt1
);

  logic             res_valid_q;
  logic [WIDTH:0]   res_data_q;
  logic             res_id_q;
  logic             last_grant_q;
  logic [7:0]       grant_cnt0_q;
  logic [7:0]       grant_cnt1_q;

  logic             slot_free;
  logic             any_valid;
  logic             sel;
  logic             accept;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [1:0]       sel_op;
  logic [WIDTH:0]   alu_result;

  assign slot_free = !res_valid_q || res_ready;
  assign any_valid = req0_valid || req1_valid;

  // On a tie the requester not granted last wins; otherwise the lone valid one.
  always_comb begin
    if (req0_valid && req1_valid) begin
      sel = !last_grant_q;
    end else begin
      sel = req1_valid;
    end
  end

  assign accept     = rst_n && slot_free && any_valid;
  assign req0_ready = accept && !sel;
  assign req1_ready = accept && sel;

  assign sel_a  = sel ? req1_a  : req0_a;
  assign sel_b  = sel ? req1_b  : req0_b;
  assign sel_op = sel ? req1_op : req0_op;

  alu_core #(
    .WIDTH (WIDTH)
  ) u_alu_core (
    .a      (sel_a),
    .b      (sel_b),
    .op     (sel_op),
    .result (alu_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      res_id_q     <= 1'b0;
      last_grant_q <= 1'b1;
      grant_cnt0_q <= 8'd0;
      grant_cnt1_q <= 8'd0;
    end else if (accept) begin
      res_valid_q  <= 1'b1;
      res_data_q   <= alu_result;
      res_id_q     <= sel;
      last_grant_q <= sel;
      if (sel) begin
        grant_cnt1_q <= grant_cnt1_q + 8'd1;
      end else begin
        grant_cnt0_q <= grant_cnt0_q + 8'd1;
      end
    end else if (res_ready) begin
      res_valid_q <= 1'b0;
    end
  end

  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign res_id     = res_id_q;
  assign grant_cnt0 = grant_cnt0_q;
  assign grant_cnt1 = grant_cnt1_q;

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed and random stimulus for alu_rr_arbiter, checked against a behavioural model.
module tb_alu_rr_arbiter;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req1_valid;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0]   req0_op, req1_op;
  logic         req0_ready, req1_ready;
  logic         res_valid, res_ready;
  logic [W:0]   res_data;
  logic         res_id;
  logic [7:0]   grant_cnt0, grant_cnt1;

  alu_rr_arbiter #(
    .WIDTH (W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_op    (req0_op),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_op    (req1_op),
    .req1_ready (req1_ready),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_id     (res_id),
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model state: pending result, its producer, round-robin memory, accept counts.
  bit m_valid;
  int m_data;
  int m_id;
  int m_last;
  int m_cnt0;
  int m_cnt1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int alu_ref(input int a, input int b, input int op);
    int m;
    m = 1 << (W + 1);
    case (op)
      0:       return a + b;
      1:       return a | b;
      2:       return (a - b + m) % m;
      default: return a ^ b;
    endcase
  endfunction

  task automatic model_reset();
    m_valid = 0;
    m_data  = 0;
    m_id    = 0;
    m_last  = 1;
    m_cnt0  = 0;
    m_cnt1  = 0;
  endtask

  task automatic drive(input bit v0, input int a0, input int b0, input int op0,
                       input bit v1, input int a1, input int b1, input int op1,
                       input bit rr);
    req0_valid = v0; req0_a = W'(a0); req0_b = W'(b0); req0_op = 2'(op0);
    req1_valid = v1; req1_a = W'(a1); req1_b = W'(b1); req1_op = 2'(op1);
    res_ready  = rr;
  endtask

  task automatic drive_random();
    drive($urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 15),
          $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 15),
          $urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 3) != 0);
  endtask

  // Checks readys for the current inputs, clocks once, then checks registered outputs.
  task automatic step();
    bit free;
    int win;
    #1;
    free = !m_valid || res_ready;
    win  = -1;
    if (free) begin
      if (req0_valid && req1_valid) win = (m_last == 1) ? 0 : 1;
      else if (req0_valid) win = 0;
      else if (req1_valid) win = 1;
    end
    chk("req0_ready", 32'(req0_ready), 32'(win == 0));
    chk("req1_ready", 32'(req1_ready), 32'(win == 1));
    if (win == 0) begin
      m_data = alu_ref(int'(req0_a), int'(req0_b), int'(req0_op));
      m_cnt0++;
    end else if (win == 1) begin
      m_data = alu_ref(int'(req1_a), int'(req1_b), int'(req1_op));
      m_cnt1++;
    end
    @(posedge clk);
    #1;
    if (win >= 0) begin
      m_valid = 1;
      m_id    = win;
      m_last  = win;
    end else if (res_ready) begin
      m_valid = 0;
    end
    chk("res_valid", 32'(res_valid), 32'(m_valid));
    if (m_valid) begin
      chk("res_data", 32'(res_data), 32'(m_data));
      chk("res_id", 32'(res_id), 32'(m_id));
    end
    chk("grant_cnt0", 32'(grant_cnt0), 32'(m_cnt0 % 256));
    chk("grant_cnt1", 32'(grant_cnt1), 32'(m_cnt1 % 256));
  endtask

  initial begin
    int ids [4];
    rst_n = 1'b0;
    drive(1, 15, 1, 0, 0, 0, 0, 0, 1);
    model_reset();
    #3;
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_data", 32'(res_data), 32'd0);
    chk("rst_res_id", 32'(res_id), 32'd0);
    chk("rst_cnt0", 32'(grant_cnt0), 32'd0);
    chk("rst_cnt1", 32'(grant_cnt1), 32'd0);
    chk("rst_ready0_low", 32'(req0_ready), 32'd0);
    #9;
    rst_n = 1'b1;

    // Lone req0 add with carry: F+1 = 10.
    step();
    chk("add_carry_data", 32'(res_data), 32'h10);
    chk("add_carry_cnt0", 32'(grant_cnt0), 32'd1);

    // Lone req1 subtract with borrow, then xor.
    drive(0, 0, 0, 0, 1, 3, 5, 2, 1);
    step();
    chk("sub_borrow_data", 32'(res_data), 32'h1e);
    chk("sub_borrow_id", 32'(res_id), 32'd1);
    drive(0, 0, 0, 0, 1, 10, 5, 3, 1);
    step();
    chk("xor_data", 32'(res_data), 32'h0f);

    // Fresh reset, then a continuous tie: grants alternate starting with requester 0.
    rst_n = 1'b0;
    model_reset();
    #2;
    rst_n = 1'b1;
    drive(1, 1, 2, 1, 1, 4, 8, 0, 1);
    for (int i = 0; i < 4; i++) begin
      step();
      ids[i] = int'(res_id);
    end
    chk("rr_seq0", 32'(ids[0]), 32'd0);
    chk("rr_seq1", 32'(ids[1]), 32'd1);
    chk("rr_seq2", 32'(ids[2]), 32'd0);
    chk("rr_seq3", 32'(ids[3]), 32'd1);

    // Back-pressure for three cycles, then release: new result loaded, valid stays high.
    drive(1, 7, 7, 0, 1, 9, 3, 2, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      req0_a = W'($urandom_range(0, 15));
      req1_b = W'($urandom_range(0, 15));
    end
    res_ready = 1'b1;
    step();
    chk("stall_release_valid", 32'(res_valid), 32'd1);

    // Asynchronous reset between edges discards the pending result.
    drive(1, 2, 3, 0, 0, 0, 0, 0, 0);
    step();
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(res_valid), 32'd0);
    chk("async_rst_cnt0", 32'(grant_cnt0), 32'd0);
    chk("async_rst_cnt1", 32'(grant_cnt1), 32'd0);
    chk("async_rst_ready0", 32'(req0_ready), 32'd0);
    model_reset();
    #2;
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step();
    step();
    chk("no_stale_result", 32'(res_valid), 32'd0);

    // 256 accepts on requester 0 wrap its counter.
    drive(1, 5, 6, 3, 0, 0, 0, 0, 1);
    for (int i = 0; i < 256; i++) step();
    chk("cnt0_wrap", 32'(grant_cnt0), 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      drive_random();
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
